// File: rtl/pixel_scheduler_if.sv
// Handshake bundle between the pixel scheduler, its two worker lanes and the output stream.
// The slave modport is the scheduler's view; the master modport is the surrounding system's view.
interface pixel_scheduler_if #(
    parameter int DIM_W = 16
) ();
    logic             start;
    logic [DIM_W-1:0] image_width;
    logic [DIM_W-1:0] image_height;
    logic             busy;
    logic             done;
    logic [1:0]       job_valid;
    logic [1:0]       job_ready;
    logic [DIM_W-1:0] job_x;
    logic [DIM_W-1:0] job_y;
    logic [1:0]       res_valid;
    logic [1:0]       res_ready;
    logic [63:0]      res_data;
    logic             m_axis_tvalid;
    logic [31:0]      m_axis_tdata;
    logic             m_axis_tlast;
    logic             m_axis_tready;

    modport slave (
        input  start, image_width, image_height, job_ready, res_valid, res_data, m_axis_tready,
        output busy, done, job_valid, job_x, job_y, res_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport master (
        output start, image_width, image_height, job_ready, res_valid, res_data, m_axis_tready,
        input  busy, done, job_valid, job_x, job_y, res_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface

// File: rtl/pixel_scheduler.sv
// Raster-order pixel dispatcher over two alternating worker lanes, collecting results
// in the same alternation and streaming them out in pixel order.
module pixel_scheduler #(
    parameter int DIM_W   = 16,
    parameter int MAX_OUT = 4
) (
    input  logic               aclk,
    input  logic               resetn,
    pixel_scheduler_if.slave   bus
);
    localparam int TOT_W = 2 * DIM_W;
    localparam logic [DIM_W-1:0] ONE_DIM = {{(DIM_W-1){1'b0}}, 1'b1};
    localparam logic [TOT_W-1:0] ONE_TOT = {{(TOT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       MAX_CNT = 4'(MAX_OUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
    logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
    logic [TOT_W-1:0] total_q, total_d, collected_q, collected_d;
    logic [3:0]       cnt_q [2];
    logic [3:0]       cnt_d [2];
    logic             disp_q, disp_d, coll_q, coll_d;
    logic             tvalid_q, tvalid_d, tlast_q, tlast_d, done_q, done_d;
    logic [31:0]      tdata_q, tdata_d;

    logic [1:0] job_valid_s, res_ready_s, job_hs_v_s, res_hs_v_s;
    logic       job_hs_s, res_hs_s, out_hs_s, frame_end_s, last_pix_s;
    logic       start_ok_s, start_zero_s;

    assign job_hs_v_s   = job_valid_s & bus.job_ready;
    assign res_hs_v_s   = res_ready_s & bus.res_valid;
    assign job_hs_s     = |job_hs_v_s;
    assign res_hs_s     = |res_hs_v_s;
    assign out_hs_s     = tvalid_q & bus.m_axis_tready;
    assign frame_end_s  = out_hs_s & tlast_q;
    assign last_pix_s   = (x_q == width_q - ONE_DIM) && (y_q == height_q - ONE_DIM);
    assign start_ok_s   = (state_q == ST_IDLE) && bus.start &&
                          (bus.image_width != '0) && (bus.image_height != '0);
    assign start_zero_s = (state_q == ST_IDLE) && bus.start &&
                          ((bus.image_width == '0) || (bus.image_height == '0));

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            width_q     <= '0;
            height_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            total_q     <= '0;
            collected_q <= '0;
            cnt_q[0]    <= 4'd0;
            cnt_q[1]    <= 4'd0;
            disp_q      <= 1'b0;
            coll_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= 32'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            x_q         <= x_d;
            y_q         <= y_d;
            total_q     <= total_d;
            collected_q <= collected_d;
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            disp_q      <= disp_d;
            coll_q      <= coll_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) state_d = ST_RUN;
                else            state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (job_hs_s && last_pix_s) state_d = ST_DRAIN;
                else                        state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (frame_end_s) state_d = ST_IDLE;
                else             state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane selection: only the pointed-to lane may request or accept, and collection stalls on output backpressure
    always_comb begin
        job_valid_s = 2'b00;
        res_ready_s = 2'b00;
        if ((state_q == ST_RUN) && (cnt_q[disp_q] < MAX_CNT)) begin
            job_valid_s[disp_q] = 1'b1;
        end else begin
            job_valid_s = 2'b00;
        end
        if ((state_q != ST_IDLE) && (cnt_q[coll_q] != 4'd0) && (!tvalid_q || bus.m_axis_tready)) begin
            res_ready_s[coll_q] = 1'b1;
        end else begin
            res_ready_s = 2'b00;
        end
    end

    // Datapath next values: frame setup, raster advance, outstanding counts and output staging
    always_comb begin
        width_d     = width_q;
        height_d    = height_q;
        x_d         = x_q;
        y_d         = y_q;
        total_d     = total_q;
        collected_d = collected_q;
        cnt_d[0]    = cnt_q[0];
        cnt_d[1]    = cnt_q[1];
        disp_d      = disp_q;
        coll_d      = coll_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        done_d      = start_zero_s | frame_end_s;
        if (start_ok_s) begin
            width_d     = bus.image_width;
            height_d    = bus.image_height;
            total_d     = TOT_W'(bus.image_width) * TOT_W'(bus.image_height);
            x_d         = '0;
            y_d         = '0;
            collected_d = '0;
            cnt_d[0]    = 4'd0;
            cnt_d[1]    = 4'd0;
            disp_d      = 1'b0;
            coll_d      = 1'b0;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
        end else begin
            if (job_hs_s) begin
                disp_d = ~disp_q;
                if (x_q == width_q - ONE_DIM) begin
                    x_d = '0;
                    y_d = y_q + ONE_DIM;
                end else begin
                    x_d = x_q + ONE_DIM;
                end
            end else begin
                disp_d = disp_q;
            end
            for (int l = 0; l < 2; l++) begin
                case ({job_hs_v_s[l], res_hs_v_s[l]})
                    2'b10:   cnt_d[l] = cnt_q[l] + 4'd1;
                    2'b01:   cnt_d[l] = cnt_q[l] - 4'd1;
                    default: cnt_d[l] = cnt_q[l];
                endcase
            end
            if (res_hs_s) begin
                tdata_d     = coll_q ? bus.res_data[63:32] : bus.res_data[31:0];
                tvalid_d    = 1'b1;
                tlast_d     = (collected_q == total_q - ONE_TOT);
                coll_d      = ~coll_q;
                collected_d = collected_q + ONE_TOT;
            end else if (out_hs_s) begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end else begin
                tvalid_d = tvalid_q;
            end
        end
    end

    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.done          = done_q;
    assign bus.job_valid     = job_valid_s;
    assign bus.job_x         = x_q;
    assign bus.job_y         = y_q;
    assign bus.res_ready     = res_ready_s;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tlast  = tlast_q;
endmodule
